// File: rtl/hazard_control_unit.sv
// Decode-stage hazard sequencer: register scoreboard, divider-occupancy and branch-flush control.
// Optional WB_BYPASS_EN: a register being written back this cycle counts as ready for hazard checks.
module hazard_control_unit #(
    parameter int NREGS        = 16,
    parameter int DIV_LATENCY  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_ra,
    input  logic [3:0]       id_rb,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic [3:0]       id_rd,
    input  logic             id_writes_rd,
    input  logic             id_is_div,
    input  logic             ex_branch_taken,
    input  logic             wb_we,
    input  logic [3:0]       wb_rd,
    output logic             if_en,
    output logic             id_en,
    output logic             if_flush,
    output logic             id_flush,
    output logic             stall,
    output logic [NREGS-1:0] busy_mask
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] DIV_LOAD   = 4'(DIV_LATENCY);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [3:0]       div_cnt_q, div_cnt_d;
    logic [NREGS-1:0] busy_q, busy_d, busy_chk;
    logic             raw, waw, divh, flush_active, issue;

    always_comb begin
        busy_chk = busy_q;
`ifdef WB_BYPASS_EN
        if (wb_we) busy_chk[wb_rd] = 1'b0;
`else
`endif
    end

    // Outputs are forced to their idle values while rst is low.
    assign flush_active = rst & (ex_branch_taken | (state_q == FLUSH));
    assign raw   = id_valid & ((id_uses_ra & busy_chk[id_ra]) | (id_uses_rb & busy_chk[id_rb]));
    assign waw   = id_valid & id_writes_rd & busy_chk[id_rd];
    assign divh  = id_valid & id_is_div & (div_cnt_q != 4'd0);
    assign stall = rst & (raw | waw | divh) & ~flush_active;
    assign issue = rst & id_valid & ~stall & ~flush_active;

    assign if_en     = ~stall;
    assign id_en     = ~stall;
    assign if_flush  = flush_active;
    assign id_flush  = flush_active;
    assign busy_mask = busy_q;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        div_cnt_d   = div_cnt_q;
        busy_d      = busy_q;

        if (ex_branch_taken) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (state_q == FLUSH && flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end
        state_d = (flush_cnt_d != 3'd0) ? FLUSH : RUN;

        if (issue && id_is_div) begin
            div_cnt_d = DIV_LOAD;
        end else if (div_cnt_q != 4'd0) begin
            div_cnt_d = div_cnt_q - 4'd1;
        end

        // Issue's set is applied after the writeback clear so it wins on a shared index.
        if (wb_we) busy_d[wb_rd] = 1'b0;
        if (issue && id_writes_rd) busy_d[id_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            div_cnt_q   <= 4'd0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            div_cnt_q   <= div_cnt_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Sequences the instruction-decode stage of the pipelined core: decides each cycle whether the decode buffer captures, holds or is bubbled.
- Tracks in-flight register writes in a 16-entry scoreboard; stalls on RAW/WAW hazards and on divider occupancy; flushes fetch/decode after a taken branch.
- Sits between fetch, decode and execute. Drives the decode stage's en input and the fetch-stage enable.

Parameters:
- NREGS, 16, number of architectural registers; scoreboard width. Register index width is 4.
- DIV_LATENCY, 4, cycles the divider stays busy after a div issues; legal range 1..15.
- FLUSH_CYCLES, 2, cycles if_flush/id_flush stay asserted per taken branch; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (clears state on a rising edge while 0).
- id_valid  in  1  decode stage holds a valid instruction.
- id_ra  in  4  source register A index.
- id_rb  in  4  source register B index.
- id_uses_ra  in  1  instruction reads Ra.
- id_uses_rb  in  1  instruction reads Rb.
- id_rd  in  4  destination register index.
- id_writes_rd  in  1  instruction writes Rd.
- id_is_div  in  1  instruction is a div.
- ex_branch_taken  in  1  branch resolved taken in execute this cycle.
- wb_we  in  1  writeback write-enable.
- wb_rd  in  4  writeback destination index.
- if_en  out  1  fetch/PC advance enable.
- id_en  out  1  decode buffer capture enable (drives decode en).
- if_flush  out  1  squash fetched instruction.
- id_flush  out  1  load NOP (all-zero) into decode buffer.
- stall  out  1  hazard stall indicator.
- busy_mask  out  16  scoreboard contents; bit i set means ri has a pending write.

Behaviour:
- Reset (rst==0 at a clock edge):
  - busy_mask=0, divider counter=0, flush counter=0, FSM=RUN.
  - Outputs during reset: stall=0, if_flush=0, id_flush=0, if_en=1, id_en=1.
- FSM states:
  - RUN: normal operation.
  - FLUSH: flush counter nonzero.
- Hazard terms (combinational from registered state):
  - raw = id_valid & ((id_uses_ra & busy[id_ra]) | (id_uses_rb & busy[id_rb])).
  - waw = id_valid & id_writes_rd & busy[id_rd].
  - divh = id_valid & id_is_div & (div_cnt!=0).
  - stall = (raw | waw | divh) & !flush_active.
- flush_active = ex_branch_taken | (state==FLUSH). if_flush = id_flush = flush_active.
- Priority: flush over stall over issue.
- Enables:
  - if_en = !stall (fetch advances during flush so the target is fetched).
  - id_en = !stall.
- Issue = id_valid & !stall & !flush_active. On issue:
  - If id_writes_rd, set busy[id_rd].
  - If id_is_div, load div_cnt with DIV_LATENCY.
- Divider counter: when nonzero and not being loaded this cycle, decrements by 1 per cycle; it never wraps below 0.
- Writeback: wb_we clears busy[wb_rd] at the edge.
  - Same-cycle issue setting and wb clearing the same index: set wins. This cannot occur through waw, because the bit must already be clear for that issue.
- Branch:
  - ex_branch_taken in cycle N: flush asserted in cycle N combinationally.
  - Flush counter loads FLUSH_CYCLES-1 and FSM enters FLUSH if that value is nonzero.
  - In FLUSH: decrement each cycle; return to RUN when the counter reaches 0.
  - Total flush duration is FLUSH_CYCLES cycles.
  - ex_branch_taken while already in FLUSH reloads the counter (restarts the window).
- Squashed instructions never touch the scoreboard or divider counter.
- Reset mid-flush or mid-div returns everything to reset values at that edge.
- Instruction word 0 (sub r0,r0,r0 used as NOP) is decoded upstream with id_writes_rd=1; it marks r0 busy normally.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: for raw/waw evaluation, a register with wb_we & wb_rd==index in the current cycle counts as not busy. This assumes a register file with write-before-read, and removes one stall cycle per dependency.
- Undefined: hazard check uses registered busy_mask only. The consumer stalls through the writeback cycle and issues the cycle after.

Test Plan:
- Reset hold: rst=0 for 2 cycles with ex_branch_taken=1 and id_valid=1 -> busy_mask=0, stall=0, if_flush=0, if_en=1, id_en=1.
- RAW: issue div r10,r6,#15 (rd=10), then consumer with ra=10 -> busy_mask=16'h0400, stall=1, id_en=0 until wb_we=1,wb_rd=10. Without WB_BYPASS_EN the consumer issues the cycle after WB; with it, in the WB cycle.
- Divider structural: two back-to-back divs (rd=1, rd=2), DIV_LATENCY=4 -> second stalls exactly 4 cycles, issues on cycle 5; busy_mask=16'h0006 afterwards.
- Taken branch: ex_branch_taken=1 for one cycle -> if_flush=id_flush=1 for exactly 2 cycles, no scoreboard change from squashed rd=15, state back to RUN.
- Flush beats stall: RAW hazard pending and ex_branch_taken=1 same cycle -> stall=0, id_flush=1, if_en=1.
- WAW plus reset: ld r15 issued (busy[15]=1), second writer rd=15 stalls; rst=0 mid-stall -> next cycle busy_mask=0, stall=0.
